// File: rtl/hazard_stall_control.sv
// Pipeline stall/flush controller: one-bubble load-use interlock plus a
// multi-cycle divide that freezes the front end until its result is ready.
module hazard_stall_control #(
    parameter int REG_W      = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_useRt_i,
    input  logic             id_ex_memRead_i,
    input  logic [REG_W-1:0] id_ex_reg3_i,
    input  logic             ex_divStart_i,
    input  logic             ex_divCancel_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_bubble_o,
    output logic             div_busy_o,
    output logic             div_done_o
);

    typedef enum logic [1:0] {IDLE, LU_HOLD, DIV_BUSY, DIV_DONE} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 2);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       w_lu;
    logic       w_pc_write, w_if_id_write, w_id_ex_flush;
    logic       w_ex_mem_bubble, w_div_busy, w_div_done;

    assign w_lu = id_ex_memRead_i && (id_ex_reg3_i != '0) &&
                  ((id_ex_reg3_i == id_rs_i) || (id_useRt_i && (id_ex_reg3_i == id_rt_i)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_div_busy      = 1'b0;
        w_div_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (ex_divStart_i) begin
                    w_pc_write      = 1'b0;
                    w_if_id_write   = 1'b0;
                    w_ex_mem_bubble = 1'b1;
                    w_div_busy      = 1'b1;
                    w_cnt_nxt       = CNT_LOAD;
                    // A two-cycle divide has no busy cycles between accept and done.
                    w_state_nxt     = (DIV_CYCLES <= 2) ? DIV_DONE : DIV_BUSY;
                end else if (w_lu) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_state_nxt   = LU_HOLD;
                end
            end
            LU_HOLD: w_state_nxt = IDLE;
            DIV_BUSY: begin
                w_pc_write      = 1'b0;
                w_if_id_write   = 1'b0;
                w_ex_mem_bubble = 1'b1;
                w_div_busy      = 1'b1;
                if (ex_divCancel_i) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    // Leave on the cycle the count reaches zero so the accept
                    // cycle plus busy cycles total DIV_CYCLES-1.
                    w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 8'd1;
                    if (r_cnt <= 8'd1)
                        w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_state_nxt = IDLE;
                if (ex_divCancel_i) begin
                    w_ex_mem_bubble = 1'b1;
                    w_cnt_nxt       = '0;
                end else begin
                    w_div_done = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Hold outputs at their released values while reset is asserted.
    assign pc_write_o      = rst_n ? w_pc_write      : 1'b1;
    assign if_id_write_o   = rst_n ? w_if_id_write   : 1'b1;
    assign id_ex_flush_o   = rst_n ? w_id_ex_flush   : 1'b0;
    assign ex_mem_bubble_o = rst_n ? w_ex_mem_bubble : 1'b0;
    assign div_busy_o      = rst_n ? w_div_busy      : 1'b0;
    assign div_done_o      = rst_n ? w_div_done      : 1'b0;

endmodule

// File: doc/hazard_stall_control.md
HAZARD_STALL_CONTROL -- requirements
Module: hazard_stall_control

Interface
REQ-001 Parameter: REG_W, 5, register-specifier width in an instruction.
REQ-002 Parameter: DIV_CYCLES, 32, EX-stage cycles a divide occupies (legal range 2..255).
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: id_rs_i  in  REG_W  rs of instruction in IF/ID.
REQ-006 Port: id_rt_i  in  REG_W  rt of instruction in IF/ID.
REQ-007 Port: id_useRt_i  in  1  IF/ID instruction reads rt.
REQ-008 Port: id_ex_memRead_i  in  1  ID/EX instruction is a load.
REQ-009 Port: id_ex_reg3_i  in  REG_W  destination register of ID/EX instruction.
REQ-010 Port: ex_divStart_i  in  1  divide entering EX this cycle.
REQ-011 Port: ex_divCancel_i  in  1  exception/flush aborting an in-flight divide.
REQ-012 Port: pc_write_o  out  1  PC may update.
REQ-013 Port: if_id_write_o  out  1  IF/ID may load.
REQ-014 Port: id_ex_flush_o  out  1  load a bubble into ID/EX.
REQ-015 Port: ex_mem_bubble_o  out  1  load a bubble into EX/MEM.
REQ-016 Port: div_busy_o  out  1  divide in progress.
REQ-017 Port: div_done_o  out  1  one-cycle divide-result-valid strobe.

Function
REQ-018 States: IDLE, LU_HOLD, DIV_BUSY, DIV_DONE; 8-bit down-counter cnt.
REQ-019 Load-use hazard (lu) = id_ex_memRead_i & (id_ex_reg3_i != 0) & ((id_ex_reg3_i == id_rs_i) | (id_useRt_i & id_ex_reg3_i == id_rt_i)).
REQ-020 IDLE, lu=0, ex_divStart_i=0: pc_write_o=1, if_id_write_o=1, id_ex_flush_o=0, ex_mem_bubble_o=0; stay IDLE.
REQ-021 IDLE, lu=1, ex_divStart_i=0: same cycle pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; next state LU_HOLD.
REQ-022 LU_HOLD: all stall/flush outputs released (pc_write_o=1, if_id_write_o=1, flushes 0), lu ignored; next state IDLE (exactly one bubble per load-use).
REQ-023 IDLE, ex_divStart_i=1 (takes priority over lu): same cycle pc_write_o=0, if_id_write_o=0, id_ex_flush_o=0, ex_mem_bubble_o=1; load cnt=DIV_CYCLES-2; next state DIV_BUSY.
REQ-024 DIV_BUSY: pc_write_o=0, if_id_write_o=0, ex_mem_bubble_o=1, div_busy_o=1; cnt decrements each cycle; when cnt==0 next state DIV_DONE.
REQ-025 DIV_DONE: div_done_o=1, div_busy_o=0, pc_write_o=1, if_id_write_o=1, ex_mem_bubble_o=0; next state IDLE; total stall = DIV_CYCLES-1 cycles plus DIV_DONE cycle.
REQ-026 ex_divStart_i outside IDLE is ignored.
REQ-027 ex_divCancel_i=1 in DIV_BUSY or DIV_DONE: that cycle div_done_o=0, ex_mem_bubble_o=1; next state IDLE, cnt=0; no div_done_o pulse.
REQ-028 ex_divCancel_i in IDLE or LU_HOLD has no effect.
REQ-029 div_busy_o=1 in DIV_BUSY and in the IDLE cycle that accepts ex_divStart_i; 0 otherwise.
REQ-030 Outputs are combinational from state, cnt and inputs; no output glitch-sensitive logic crosses clock domains.

Reset
REQ-031 rst_n=0 forces state IDLE, cnt=0 asynchronously, at any time including mid-divide.
REQ-032 During reset: pc_write_o=1, if_id_write_o=1, id_ex_flush_o=0, ex_mem_bubble_o=0, div_busy_o=0, div_done_o=0.
REQ-033 First rising edge after rst_n deasserts evaluates from IDLE; no divide resumes.

Verification
REQ-034 id_ex_memRead=1, reg3=8, id_rs=8 -> cycle0 pc_write=0, if_id_write=0, id_ex_flush=1; cycle1 all released despite unchanged inputs.
REQ-035 id_ex_memRead=1, reg3=0, id_rs=0 -> no stall; reg3=9, id_rt=9, useRt=0 -> no stall.
REQ-036 ex_divStart=1 pulse, DIV_CYCLES=32 -> pc_write=0 for 31 cycles, div_done=1 in cycle 31 only, back to IDLE cycle 32.
REQ-037 ex_divStart and lu both 1 in IDLE -> divide sequence, id_ex_flush=0; second ex_divStart mid-divide ignored.
REQ-038 ex_divCancel=1 at divide cycle 10 -> ex_mem_bubble=1 that cycle, IDLE next, no div_done pulse.
REQ-039 rst_n low at divide cycle 5 -> outputs at reset values immediately; after release, lu with reg3=rs stalls normally.
